// File: rtl/src_switch_seq.sv
// ----------------------------------------------------------------------------
// src_switch_seq
//
// Sequences a glitch-free change of the video clock source between the
// on-board clocks and the recovered HDMI clocks. It runs in the clk10
// housekeeping domain, directly downstream of the HDMI clock-activity
// detector.
//
// The block does four things:
//   - qualifies the raw select decision, rejecting short glitches;
//   - holds the video pipeline in reset around the change;
//   - drives the BUFGMUX select;
//   - releases the pipeline only after the new clock has settled.
//
// Optional feature:
//   SRC_SWITCH_VSYNC_ALIGN_EN - when defined, the pipeline reset is aligned to
//   a vsync rising edge of the outgoing source. A dead source still switches
//   after VS_TIMEOUT cycles. When undefined, vsync_async is unused.
//
// Ports:
//   clk10       in   10 MHz housekeeping clock (the only clock)
//   rst         in   asynchronous, active-high reset
//   sel_req     in   raw source decision (1 = HDMI, 0 = local), clk10-synchronous
//   vsync_async in   vsync of the currently selected video domain, asynchronous
//   mux_sel     out  BUFGMUX select for all three clock muxes (registered)
//   pipe_rst    out  video-pipeline reset, active-high (registered)
//   locked      out  high while in RUN (registered)
//   switch_cnt  out  completed switches, saturating at 255
//   state_dbg   out  current state encoding for an ILA probe
// ----------------------------------------------------------------------------
module src_switch_seq #(
    parameter int STABLE_CNT = 50000,
    parameter int RST_HOLD   = 1000,
    parameter int SETTLE     = 10000,
    parameter int VS_TIMEOUT = 200000
) (
    input  logic       clk10,
    input  logic       rst,
    input  logic       sel_req,
    input  logic       vsync_async,
    output logic       mux_sel,
    output logic       pipe_rst,
    output logic       locked,
    output logic [7:0] switch_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_RUN    = 3'd1,
        ST_QUAL   = 3'd2,
        ST_VSWAIT = 3'd3,
        ST_HOLD   = 3'd4,
        ST_SWITCH = 3'd5
    } state_t;

    // Terminal counts of the single shared 24-bit counter.
    localparam logic [23:0] LP_STABLE_M1 = 24'(STABLE_CNT - 1);
    localparam logic [23:0] LP_HOLD_M1   = 24'(RST_HOLD - 1);
    localparam logic [23:0] LP_SETTLE_M1 = 24'(SETTLE - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [23:0] r_cnt;
    logic        r_sel_q;
    logic        r_mux_sel;
    logic        r_pipe_rst;
    logic        r_locked;
    logic [7:0]  r_switch_cnt;
    logic        w_next_pipe_rst;
    logic        w_next_locked;

`ifdef SRC_SWITCH_VSYNC_ALIGN_EN
    localparam logic [23:0] LP_VS_M1 = 24'(VS_TIMEOUT - 1);

    logic r_vs_meta;
    logic r_vs_sync;
    logic r_vs_prev;
    logic w_vs_rise;

    // Two-flop synchronizer, then a rising-edge detect on the synchronized level.
    always_ff @(posedge clk10 or posedge rst) begin
        if (rst) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= vsync_async;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_vs_rise = r_vs_sync & ~r_vs_prev;
`else
    // vsync alignment is compiled out; the pin and its timeout are
    // intentionally left unused.
    localparam int unused_vs_timeout = VS_TIMEOUT;
    logic w_unused_vsync;
    assign w_unused_vsync = vsync_async;
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_SETTLE: begin
                if (r_cnt == LP_SETTLE_M1) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (r_sel_q != r_mux_sel) w_next_state = ST_QUAL;
            end
            ST_QUAL: begin
                // The request fell back before qualifying: treat it as a glitch.
                if (r_sel_q == r_mux_sel) begin
                    w_next_state = ST_RUN;
                end else if (r_cnt == LP_STABLE_M1) begin
`ifdef SRC_SWITCH_VSYNC_ALIGN_EN
                    w_next_state = ST_VSWAIT;
`else
                    w_next_state = ST_HOLD;
`endif
                end
            end
`ifdef SRC_SWITCH_VSYNC_ALIGN_EN
            ST_VSWAIT: begin
                // An abort wins over a coincident vsync edge or timeout.
                if (r_sel_q == r_mux_sel) begin
                    w_next_state = ST_RUN;
                end else if (w_vs_rise || (r_cnt == LP_VS_M1)) begin
                    w_next_state = ST_HOLD;
                end
            end
`endif
            // sel_q is deliberately ignored from HOLD until RUN is reached again.
            ST_HOLD: begin
                if (r_cnt == LP_HOLD_M1) w_next_state = ST_SWITCH;
            end
            ST_SWITCH: begin
                w_next_state = ST_SETTLE;
            end
            default: begin
                w_next_state = ST_SETTLE;
            end
        endcase
    end

    // The pipeline stays in reset from HOLD through the end of SETTLE. The mux
    // select therefore only ever changes deep inside a reset window.
    always_comb begin
        w_next_pipe_rst = (w_next_state == ST_SETTLE) ||
                          (w_next_state == ST_HOLD)   ||
                          (w_next_state == ST_SWITCH);
        w_next_locked   = (w_next_state == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk10 or posedge rst) begin
        if (rst) begin
            r_state      <= ST_SETTLE;
            r_cnt        <= '0;
            r_sel_q      <= 1'b0;
            r_mux_sel    <= 1'b0;
            r_pipe_rst   <= 1'b1;
            r_locked     <= 1'b0;
            r_switch_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_sel_q    <= sel_req;
            r_pipe_rst <= w_next_pipe_rst;
            r_locked   <= w_next_locked;

            // One shared counter, cleared on every state transition.
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 24'd1;
            end

            if (r_state == ST_SWITCH) begin
                r_mux_sel <= ~r_mux_sel;
                if (r_switch_cnt != 8'd255) begin
                    r_switch_cnt <= r_switch_cnt + 8'd1;
                end
            end
        end
    end

    assign mux_sel    = r_mux_sel;
    assign pipe_rst   = r_pipe_rst;
    assign locked     = r_locked;
    assign switch_cnt = r_switch_cnt;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_src_switch_seq.sv
// ----------------------------------------------------------------------------
// tb_src_switch_seq
//
// Directed, self-checking bench for src_switch_seq. It uses short timing
// parameters: STABLE_CNT=4, RST_HOLD=3, SETTLE=5 and VS_TIMEOUT=20.
//
// Per-edge vectors for glitch rejection and a full switch are held in a
// table. Hand-written sequences cover the multi-cycle corners:
//   - reset release;
//   - asynchronous reset;
//   - a request withdrawn during HOLD;
//   - vsync alignment (when SRC_SWITCH_VSYNC_ALIGN_EN is defined);
//   - switch counter saturation.
// ----------------------------------------------------------------------------
module tb_src_switch_seq;

    localparam logic [2:0] S_SETTLE = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_QUAL   = 3'd2;
    localparam logic [2:0] S_VSWAIT = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_SWITCH = 3'd5;

    logic       clk10;
    logic       rst;
    logic       sel_req;
    logic       vsync_async;
    logic       mux_sel;
    logic       pipe_rst;
    logic       locked;
    logic [7:0] switch_cnt;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // One applied sel_req value and the outputs expected just after the edge.
    typedef struct {
        logic       sel;
        logic       mux;
        logic       prst;
        logic       lock;
        logic [2:0] st;
        logic [7:0] swc;
    } vec_t;

    vec_t vecs[$];

    src_switch_seq #(
        .STABLE_CNT(4),
        .RST_HOLD  (3),
        .SETTLE    (5),
        .VS_TIMEOUT(20)
    ) dut (
        .clk10      (clk10),
        .rst        (rst),
        .sel_req    (sel_req),
        .vsync_async(vsync_async),
        .mux_sel    (mux_sel),
        .pipe_rst   (pipe_rst),
        .locked     (locked),
        .switch_cnt (switch_cnt),
        .state_dbg  (state_dbg)
    );

    initial clk10 = 1'b0;
    always #5 clk10 = ~clk10;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk10);
        #1;
    endtask

    function automatic logic [2:0] probe(input int which);
        case (which)
            0:       return {2'b00, mux_sel};
            1:       return {2'b00, pipe_rst};
            2:       return {2'b00, locked};
            default: return state_dbg;
        endcase
    endfunction

    // Bounded wait for a DUT output to reach a value. An expired bound shows
    // up as a failed comparison.
    task automatic wait_for(input string name, input int which, input logic [2:0] val);
        int n = 0;
        while (probe(which) !== val && n < 400) begin
            tick();
            n++;
        end
        check(name, 32'(probe(which)), 32'(val));
    endtask

    task automatic reset_and_run();
        rst     = 1'b1;
        sel_req = 1'b0;
        tick();
        rst = 1'b0;
        wait_for("relock_after_reset", 2, 3'd1);
    endtask

    logic exp_mux;
    int   exp_swc;

    initial begin
        rst         = 1'b1;
        sel_req     = 1'b0;
        vsync_async = 1'b0;

        // ---------------- Vector table ----------------
        // Glitch: sel_req high for three cycles never qualifies.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  8'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, S_QUAL, 8'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, S_QUAL, 8'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, S_QUAL, 8'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, S_RUN,  8'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, S_RUN,  8'd0});
`ifndef SRC_SWITCH_VSYNC_ALIGN_EN
        // Full switch to HDMI. Row 0 below is edge 0 (sel_q first differs).
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, S_RUN,    8'd0});
        for (int i = 1; i <= 4; i++)
            vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, S_QUAL,   8'd0});
        for (int i = 5; i <= 7; i++)
            vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, S_HOLD,   8'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, S_SWITCH, 8'd0});
        for (int i = 9; i <= 13; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, S_SETTLE, 8'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, S_RUN,    8'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, S_RUN,    8'd1});
`endif

        // ---------------- Reset state and release ----------------
        tick();
        check("reset_state", {27'd0, mux_sel, pipe_rst, locked, state_dbg == S_SETTLE, switch_cnt == 8'd0},
              {27'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("settle_edge4_prst", 32'(pipe_rst), 32'd1);
        check("settle_edge4_lock", 32'(locked), 32'd0);
        tick();
        check("settle_edge5_prst", 32'(pipe_rst), 32'd0);
        check("settle_edge5_lock", 32'(locked), 32'd1);
        check("settle_edge5_mux", 32'(mux_sel), 32'd0);
        check("settle_edge5_swc", 32'(switch_cnt), 32'd0);
        tick();
        tick();

        // ---------------- Table-driven vectors ----------------
        foreach (vecs[i]) begin
            sel_req = vecs[i].sel;
            tick();
            check($sformatf("vec%0d{mux,prst,lock,st,swc}", i),
                  {18'd0, mux_sel, pipe_rst, locked, state_dbg, switch_cnt},
                  {18'd0, vecs[i].mux, vecs[i].prst, vecs[i].lock, vecs[i].st, vecs[i].swc});
        end

`ifdef SRC_SWITCH_VSYNC_ALIGN_EN
        // ---------------- vsync alignment ----------------
        // Pin rises 7 cycles into VSWAIT; HOLD follows 3 edges later.
        sel_req = 1'b1;
        wait_for("enter_vswait", 3, S_VSWAIT);
        for (int i = 0; i < 7; i++) tick();
        vsync_async = 1'b1;
        tick();
        check("vs_edge1_state", 32'(state_dbg), 32'(S_VSWAIT));
        tick();
        check("vs_edge2_state", 32'(state_dbg), 32'(S_VSWAIT));
        tick();
        check("vs_edge3_state", 32'(state_dbg), 32'(S_HOLD));
        check("vs_edge3_prst", 32'(pipe_rst), 32'd1);
        wait_for("vs_switch_mux", 0, 3'd1);
        wait_for("vs_switch_lock", 2, 3'd1);
        vsync_async = 1'b0;

        // No vsync: the timeout moves VSWAIT to HOLD on its 20th cycle.
        sel_req = 1'b0;
        wait_for("enter_vswait_to", 3, S_VSWAIT);
        for (int i = 0; i < 19; i++) tick();
        check("to_cycle19_state", 32'(state_dbg), 32'(S_VSWAIT));
        tick();
        check("to_cycle20_state", 32'(state_dbg), 32'(S_HOLD));
        wait_for("to_switch_mux", 0, 3'd0);
        wait_for("to_switch_lock", 2, 3'd1);
        check("to_switch_cnt", 32'(switch_cnt), 32'd2);
`endif

        // ---------------- Asynchronous reset mid-SETTLE ----------------
        reset_and_run();
        sel_req = 1'b1;
        wait_for("async_pre_mux", 0, 3'd1);
        tick();
        tick();
        check("async_pre_state", 32'(state_dbg), 32'(S_SETTLE));
        #3;
        rst = 1'b1;
        #1;
        check("async_mux", 32'(mux_sel), 32'd0);
        check("async_prst", 32'(pipe_rst), 32'd1);
        check("async_swc", 32'(switch_cnt), 32'd0);
        check("async_lock", 32'(locked), 32'd0);
        check("async_state", 32'(state_dbg), 32'(S_SETTLE));
        sel_req = 1'b0;
        tick();
        rst = 1'b0;
        wait_for("async_relock", 2, 3'd1);

        // ---------------- Request withdrawn during HOLD ----------------
        sel_req = 1'b1;
        wait_for("hold_enter_prst", 1, 3'd1);
        tick();
        sel_req = 1'b0;
        wait_for("hold_switch_mux1", 0, 3'd1);
        check("hold_swc1", 32'(switch_cnt), 32'd1);
        wait_for("hold_switch_back_mux0", 0, 3'd0);
        wait_for("hold_final_lock", 2, 3'd1);
        check("hold_final_swc", 32'(switch_cnt), 32'd2);
        check("hold_final_prst", 32'(pipe_rst), 32'd0);

        // ---------------- Saturation ----------------
        exp_mux = 1'b0;
        exp_swc = 2;
        for (int i = 0; i < 256; i++) begin
            sel_req = ~exp_mux;
            exp_mux = ~exp_mux;
            exp_swc = (exp_swc < 255) ? exp_swc + 1 : 255;
            wait_for($sformatf("sat%0d_mux", i), 0, {2'b00, exp_mux});
            wait_for($sformatf("sat%0d_lock", i), 2, 3'd1);
            check($sformatf("sat%0d_swc", i), 32'(switch_cnt), 32'(exp_swc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/src_switch_seq.md
# src_switch_seq

Sequences a glitch-free change of the video clock source between the on-board clocks and the recovered HDMI clocks. It sits directly downstream of the HDMI clock-activity detector in the `clk10` housekeeping domain. The block qualifies the detector's raw select decision, holds the video pipeline in reset around the change, drives the BUFGMUX select, and releases the pipeline only after the new clock has settled.

## Interface
Parameters:
- `STABLE_CNT`, 50000: consecutive `clk10` cycles that `sel_req` must differ from `mux_sel` before a switch starts (5 ms).
- `RST_HOLD`, 1000: cycles `pipe_rst` is held before `mux_sel` changes.
- `SETTLE`, 10000: cycles `pipe_rst` is held after `mux_sel` changes.
- `VS_TIMEOUT`, 200000: maximum cycles spent waiting for vsync. Used only with `SRC_SWITCH_VSYNC_ALIGN_EN`.
- All parameters are in the range 1 to 2^24-1. The block uses one shared 24-bit counter.

Ports:
- `clk10`  in  1  10 MHz housekeeping clock. This is the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sel_req`  in  1  raw source decision (1 = HDMI, 0 = local), synchronous to `clk10`.
- `vsync_async`  in  1  vsync from the currently selected video domain, asynchronous.
- `mux_sel`  out  1  BUFGMUX select for all three clock muxes. Registered.
- `pipe_rst`  out  1  video-pipeline reset, active-high. Registered.
- `locked`  out  1  high while in RUN. Registered.
- `switch_cnt`  out  8  count of completed switches, saturating at 255.
- `state_dbg`  out  3  current state encoding, for an ILA probe.

## Operation
- `sel_req` is registered once, as `sel_q`.
- `vsync_async` passes through a 2-flop synchronizer and then a rising-edge detect, producing `vs_rise`.
- State machine states:
  - SETTLE (reset state):
    - `pipe_rst`=1.
    - Counts to SETTLE-1, then goes to RUN.
  - RUN:
    - `pipe_rst`=0 and `locked`=1.
    - `sel_q != mux_sel` goes to QUAL and clears the counter.
  - QUAL:
    - `sel_q == mux_sel` returns to RUN. This is glitch rejection, and the counter is cleared.
    - Otherwise the block counts. At STABLE_CNT-1 it goes to HOLD, or to VSWAIT when the macro is defined.
  - VSWAIT (macro only):
    - `vs_rise`, or a counter value of VS_TIMEOUT-1, goes to HOLD.
    - `sel_q == mux_sel` returns to RUN.
  - HOLD:
    - `pipe_rst`=1.
    - Counts to RST_HOLD-1, then goes to SWITCH.
  - SWITCH:
    - Lasts one cycle.
    - On exit, `mux_sel` is inverted and `switch_cnt` is incremented unless it is at 255. The next state is SETTLE.
- Once HOLD is entered, `sel_q` is ignored until RUN is reached again. If `sel_q` still differs in RUN, a new qualification starts, which allows a switch back.
- The counter clears on every state transition.
- `pipe_rst`, `locked` and `state_dbg` are registered from the next-state value. All three change on the same edge as the state.

## Timing
- Reset values, applied immediately on `rst` assertion regardless of state:
  - `mux_sel`=0
  - `pipe_rst`=1
  - `locked`=0
  - `switch_cnt`=0
  - state=SETTLE with counter=0
- After `rst` falls, `pipe_rst` falls and `locked` rises on the SETTLE-th `clk10` edge.
- Switch timeline without the macro. Edge 0 is the edge at which `sel_q` first differs from `mux_sel` in RUN:
  - Edge 1: QUAL is entered and `locked` falls.
  - Edge 1+STABLE_CNT: `pipe_rst` rises.
  - Edge 2+STABLE_CNT+RST_HOLD: `mux_sel` toggles.
  - Edge 2+STABLE_CNT+RST_HOLD+SETTLE: `pipe_rst` falls and `locked` rises.
- Simultaneous events in VSWAIT:
  - `vs_rise` together with `sel_q == mux_sel` goes to RUN, because the abort has priority.
  - `vs_rise` together with a timeout goes to HOLD.
- Because `mux_sel` only ever changes while `pipe_rst` has been high for RST_HOLD cycles, downstream logic never sees a clock edge from the new source outside reset.

## Configuration
- `SRC_SWITCH_VSYNC_ALIGN_EN` defined:
  - QUAL exits into VSWAIT, so pipeline reset is aligned to a frame boundary of the outgoing source.
  - A dead source still switches after VS_TIMEOUT cycles.
- Macro undefined:
  - The VSWAIT state, the vsync synchronizer and VS_TIMEOUT are not compiled.
  - `vsync_async` is left unused.
  - QUAL exits directly to HOLD.

## Test plan
All scenarios use STABLE_CNT=4, RST_HOLD=3, SETTLE=5 and VS_TIMEOUT=20.
- Reset release, with `sel_req`=0 throughout -> `pipe_rst` falls and `locked` rises on edge 5; `mux_sel`=0; `switch_cnt`=0.
- `sel_req` driven to 1 in RUN and sampled at edge 0 (macro off) -> `pipe_rst` rises at edge 5, `mux_sel`=1 at edge 9, `pipe_rst` falls at edge 14, `switch_cnt`=1.
- `sel_req` pulsed to 1 for 3 cycles -> the block returns to RUN; `pipe_rst` never rises; `mux_sel` stays 0; `locked` drops for 3 cycles only.
- `sel_req` returns to 0 during HOLD -> the switch still completes with `mux_sel`=1; the block then requalifies and switches back to `mux_sel`=0; `switch_cnt`=2.
- Macro on, `vsync_async` rising 7 cycles into VSWAIT -> HOLD is entered 3 edges after the pin rises (2-flop synchronizer plus the registered state). Separately, with no vsync, HOLD is entered after 20 VSWAIT cycles.
- `rst` asserted mid-SETTLE with `mux_sel`=1 -> `mux_sel`=0, `pipe_rst`=1 and `switch_cnt`=0 immediately, with no clock edge needed. 256 forced switches -> `switch_cnt` holds at 255.
